// File: rtl/j_intsvc.sv
// Interrupt service initiator: reads INT1 on _int, presents the highest-priority source, clears it.
// Optional macro INTSVC_SPUR_CNT_EN builds a saturating spurious-interrupt counter on spur_cnt.
module j_intsvc #(
    parameter int NSRC    = 5,
    parameter int RD_WAIT = 2,
    parameter int SETTLE  = 2
) (
    input  logic            clk,
    input  logic            resetl,
    input  logic            _int,
    input  logic [NSRC-1:0] int_en,
    input  logic [15:0]     dr_in,
    input  logic            svc_ack,
    output logic            int1r,
    output logic            int1w,
    output logic [15:0]     dout,
    output logic            svc_vld,
    output logic [2:0]      svc_src,
    output logic            busy,
    output logic [7:0]      spur_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_SEL, S_PRES, S_CLR, S_SPUR, S_SETTLE
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      cnt;
    logic [NSRC-1:0] pend;
    logic [2:0]      src;
    logic            cnt_last;

    // Pending bits above NSRC carry no source and are deliberately dropped.
    logic unused_dr;
    assign unused_dr = ^dr_in[15:NSRC];

    // Lowest set bit wins: the loop runs high-to-low so bit 0 is assigned last.
    always_comb begin
        src = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i]) src = 3'(i);
        end
    end

    assign cnt_last = (state == S_RD) ? (cnt == 3'(RD_WAIT - 1))
                                      : (cnt == 3'(SETTLE - 1));

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) state <= S_IDLE;
        else         state <= state_nx;
    end

    // NOTE: every output and next-state gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        int1r    = 1'b0;
        int1w    = 1'b0;
        dout     = '0;
        svc_vld  = 1'b0;
        svc_src  = '0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE:   if (!_int) state_nx = S_RD;
            S_RD: begin
                int1r = 1'b1;
                if (cnt_last) state_nx = S_SEL;
            end
            S_SEL:    state_nx = (pend == '0) ? S_SPUR : S_PRES;
            S_PRES: begin
                svc_vld = 1'b1;
                svc_src = src;
                if (svc_ack) state_nx = S_CLR;
            end
            S_CLR: begin
                int1w    = 1'b1;
                dout     = (16'(1) << (5'(src) + 5'd8)) | 16'(int_en);
                state_nx = S_SETTLE;
            end
            S_SPUR:   state_nx = S_SETTLE;
            S_SETTLE: if (cnt_last) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments and are all cleared by the async reset,
    // so an interrupted service leaves no stale pend or count behind.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            cnt  <= '0;
            pend <= '0;
        end else begin
            if (state == S_RD || state == S_SETTLE)
                cnt <= cnt_last ? 3'd0 : cnt + 3'd1;
            else
                cnt <= '0;
            if (state == S_RD && cnt_last)
                pend <= dr_in[NSRC-1:0];
        end
    end

`ifdef INTSVC_SPUR_CNT_EN
    // SPUR lasts exactly one cycle, so counting while in it counts entries.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl)
            spur_cnt <= '0;
        else if (state == S_SPUR && spur_cnt != 8'hFF)
            spur_cnt <= spur_cnt + 8'd1;
    end
`else
    assign spur_cnt = 8'h00;
`endif

endmodule
